spi_master: RTL and testbench

- SPI bus master: mode 0 (CPOL=0, CPHA=0), 8-bit frames, MSB first; drives SCK/MOSI/SSEL, samples MISO.
- Mates with the team's SPI slave block on the same FPGA or board.
- Upstream logic supplies bytes with a valid/ready handshake and receives each byte read back from MISO.
- tx_last ends a burst; otherwise SSEL stays low between bytes.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_master_if.sv | 38 +++
 rtl/spi_sck_div.sv | 26 ++
 rtl/spi_master.sv | 140 ++++++++++++++
 tb/tb_spi_master.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared constants and FSM state encoding for the SPI master (mode 0, MSB first).
package spi_pkg;

    localparam int unsigned SPI_DATA_W          = 8;
    localparam int unsigned SPI_CLK_DIV_DEFAULT = 4;

    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        NEXT,
        TRAIL,
        GAP
    } spi_state_e;

endpackage

// File: rtl/spi_master_if.sv
// Upstream byte stream interface: tx side is valid/ready, rx side is a one-cycle valid pulse.
interface spi_master_if
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = SPI_DATA_W
) ();

    logic [DATA_W-1:0] tx_data;
    logic              tx_last;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              busy;

    // Upstream producer/consumer side.
    modport master (
        output tx_data,
        output tx_last,
        output tx_valid,
        input  tx_ready,
        input  rx_data,
        input  rx_valid,
        input  busy
    );

    // SPI master block side.
    modport slave (
        input  tx_data,
        input  tx_last,
        input  tx_valid,
        output tx_ready,
        output rx_data,
        output rx_valid,
        output busy
    );

endinterface

// File: rtl/spi_sck_div.sv
// Half-period tick generator: counts 0..CLK_DIV-1 while enabled and pulses tick on the wrap cycle.
module spi_sck_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;

    assign tick = en && (cnt_q == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: one frame per accepted byte, SSEL held low across a burst until tx_last.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = SPI_CLK_DIV_DEFAULT,
    parameter int unsigned DATA_W  = SPI_DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.slave  bus,
    output logic         SCK,
    output logic         MOSI,
    input  logic         MISO,
    output logic         SSEL
);

    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    spi_state_e        state_q;
    logic [DATA_W-1:0] tx_shift_q;
    logic [DATA_W-1:0] rx_shift_q;
    logic [DATA_W-1:0] rx_data_q;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic              last_q;
    logic              rx_valid_q;
    logic              sck_q;
    logic              mosi_q;
    logic              ssel_q;
    logic              miso_meta_q;
    logic              miso_sync_q;

    logic tick;
    logic div_en;
    logic accept;
    logic last_bit;

    assign bus.tx_ready = (state_q == IDLE) || (state_q == NEXT);
    assign bus.busy     = (state_q != IDLE);
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

    assign SCK  = sck_q;
    assign MOSI = mosi_q;
    assign SSEL = ssel_q;

    assign accept   = bus.tx_valid && bus.tx_ready;
    assign last_bit = (bit_cnt_q == BIT_W'(DATA_W - 1));

    // Counter is held at zero in the waiting states, so each timed state starts from a clean count.
    assign div_en = (state_q != IDLE) && (state_q != NEXT);

    spi_sck_div #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_div (
        .clk   (clk),
        .rst   (rst),
        .clear (!div_en),
        .en    (div_en),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
        end else begin
            miso_meta_q <= MISO;
            miso_sync_q <= miso_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sck_q      <= SPI_CPOL;
            mosi_q     <= 1'b0;
            ssel_q     <= 1'b1;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            bit_cnt_q  <= '0;
            last_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            unique case (state_q)
                IDLE, NEXT: begin
                    if (accept) begin
                        tx_shift_q <= bus.tx_data;
                        last_q     <= bus.tx_last;
                        mosi_q     <= bus.tx_data[DATA_W-1];
                        ssel_q     <= 1'b0;
                        bit_cnt_q  <= '0;
                        state_q    <= LEAD;
                    end
                end
                LEAD: begin
                    // The end of the lead-in period is the first leading (sampling) edge.
                    if (tick) begin
                        sck_q      <= ~SPI_CPOL;
                        rx_shift_q <= {rx_shift_q[DATA_W-2:0], miso_sync_q};
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (sck_q == SPI_CPOL) begin
                            sck_q      <= ~SPI_CPOL;
                            rx_shift_q <= {rx_shift_q[DATA_W-2:0], miso_sync_q};
                        end else begin
                            sck_q     <= SPI_CPOL;
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (last_bit) begin
                                rx_data_q  <= rx_shift_q;
                                rx_valid_q <= 1'b1;
                                state_q    <= last_q ? TRAIL : NEXT;
                            end else begin
                                tx_shift_q <= tx_shift_q << 1;
                                mosi_q     <= tx_shift_q[DATA_W-2];
                            end
                        end
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        ssel_q  <= 1'b1;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    if (tick) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Scoreboarded bench for spi_master: loopback, slave model bursts, stall, mid-frame reset, CLK_DIV=6.
module tb_spi_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic       tv = 1'b0;
    logic       tl = 1'b0;
    logic [7:0] td = 8'h00;
    logic       loop4 = 1'b0;
    logic       sel6 = 1'b0;
    logic       s_miso = 1'b0;

    logic sck4, mosi4, ssel4, miso4;
    logic sck6, mosi6, ssel6, miso6;

    spi_master_if #(.DATA_W(8)) if4 ();
    spi_master_if #(.DATA_W(8)) if6 ();

    assign if4.tx_valid = tv && !sel6;
    assign if4.tx_data  = td;
    assign if4.tx_last  = tl;
    assign if6.tx_valid = tv && sel6;
    assign if6.tx_data  = td;
    assign if6.tx_last  = tl;

    assign miso4 = loop4 ? mosi4 : s_miso;
    assign miso6 = s_miso;

    spi_master #(.CLK_DIV(4), .DATA_W(8)) dut4 (
        .clk  (clk),
        .rst  (rst),
        .bus  (if4),
        .SCK  (sck4),
        .MOSI (mosi4),
        .MISO (miso4),
        .SSEL (ssel4)
    );

    spi_master #(.CLK_DIV(6), .DATA_W(8)) dut6 (
        .clk  (clk),
        .rst  (rst),
        .bus  (if6),
        .SCK  (sck6),
        .MOSI (mosi6),
        .MISO (miso6),
        .SSEL (ssel6)
    );

    // View of whichever DUT is currently under test.
    wire       m_sck   = sel6 ? sck6 : sck4;
    wire       m_mosi  = sel6 ? mosi6 : mosi4;
    wire       m_ssel  = sel6 ? ssel6 : ssel4;
    wire       m_ready = sel6 ? if6.tx_ready : if4.tx_ready;
    wire       m_busy  = sel6 ? if6.busy : if4.busy;
    wire       m_rxv   = sel6 ? if6.rx_valid : if4.rx_valid;
    wire [7:0] m_rxd   = sel6 ? if6.rx_data : if4.rx_data;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: expected rx bytes, popped whenever the DUT pulses rx_valid.
    logic [7:0] exp_q[$];
    always @(negedge clk) begin
        if (m_rxv) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rx_unexpected: rx_data=0x%0h, required no rx_valid pulse", m_rxd);
            end else begin
                check("rx_data", m_rxd, exp_q.pop_front());
            end
        end
    end

    // Event recorder: cycle numbers of every edge of interest.
    int rise_q[$], fall_q[$], sf_q[$], sr_q[$], rxv_q[$], rdy_q[$];
    bit mosi_q[$];
    logic p_sck = 1'b0, p_ssel = 1'b1, p_ready = 1'b0;
    always @(negedge clk) begin
        if (m_sck && !p_sck) begin
            rise_q.push_back(cyc);
            mosi_q.push_back(m_mosi);
        end
        if (!m_sck && p_sck) fall_q.push_back(cyc);
        if (!m_ssel && p_ssel) sf_q.push_back(cyc);
        if (m_ssel && !p_ssel) sr_q.push_back(cyc);
        if (m_ready && !p_ready) rdy_q.push_back(cyc);
        if (m_rxv) rxv_q.push_back(cyc);
        p_sck   = m_sck;
        p_ssel  = m_ssel;
        p_ready = m_ready;
    end

    task automatic clear_rec();
        rise_q.delete();
        fall_q.delete();
        sf_q.delete();
        sr_q.delete();
        rxv_q.delete();
        rdy_q.delete();
        mosi_q.delete();
    endtask

    // Mode-0 slave model: samples MOSI on SCK rise, presents next MISO bit on SCK fall.
    logic [7:0] s_tx_q[$], s_rx_q[$];
    logic [7:0] s_out = 8'h00, s_in = 8'h00;
    int   s_bits = 0;
    logic s_pck = 1'b0, s_pss = 1'b1;
    always @(m_sck or m_ssel) begin
        if (m_ssel) begin
            s_bits = 0;
        end else if (s_pss) begin
            s_bits = 0;
            s_out  = (s_tx_q.size() > 0) ? s_tx_q.pop_front() : 8'h00;
            s_miso = s_out[7];
        end else if (m_sck && !s_pck) begin
            s_in = {s_in[6:0], m_mosi};
            s_bits++;
            if (s_bits == 8) s_rx_q.push_back(s_in);
        end else if (!m_sck && s_pck) begin
            if (s_bits == 8) begin
                s_bits = 0;
                s_out  = (s_tx_q.size() > 0) ? s_tx_q.pop_front() : 8'h00;
            end else begin
                s_out = s_out << 1;
            end
            s_miso = s_out[7];
        end
        s_pck = m_sck;
        s_pss = m_ssel;
    end

    task automatic wait_ready();
        int n = 0;
        while (!m_ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("tx_ready_wait", m_ready, 1);
    endtask

    task automatic send(input logic [7:0] d, input logic last, output int t0);
        wait_ready();
        td = d;
        tl = last;
        tv = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        tv = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_busy && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("busy_clear_wait", m_busy, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, t1, n, bad;
        logic [7:0] b;

        // Reset, then 20 idle cycles.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_rec();
        repeat (20) @(posedge clk);
        #1;
        check("idle_ssel", ssel4, 1);
        check("idle_sck", sck4, 0);
        check("idle_mosi", mosi4, 0);
        check("idle_ready", if4.tx_ready, 1);
        check("idle_busy", if4.busy, 0);
        check("idle_rx_data", if4.rx_data, 0);
        check("idle_rxv_count", rxv_q.size(), 0);

        // Loopback single byte 0xA5, CLK_DIV=4.
        loop4 = 1'b1;
        clear_rec();
        exp_q.push_back(8'hA5);
        send(8'hA5, 1'b1, t);
        wait_idle();
        check("a5_ssel_fall_count", sf_q.size(), 1);
        if (sf_q.size() > 0) check("a5_ssel_fall_cyc", sf_q[0] - t, 1);
        check("a5_rise_count", rise_q.size(), 8);
        for (int i = 0; i < rise_q.size(); i++) begin
            check($sformatf("a5_rise%0d_cyc", i), rise_q[i] - t, 5 + 8 * i);
        end
        b = 8'h00;
        foreach (mosi_q[i]) b = {b[6:0], mosi_q[i]};
        check("a5_mosi_bits", b, 8'hA5);
        if (rxv_q.size() > 0) check("a5_rx_valid_cyc", rxv_q[0] - t, 65);
        if (sr_q.size() > 0) check("a5_ssel_rise_cyc", sr_q[0] - t, 69);
        if (rdy_q.size() > 0) check("a5_tx_ready_cyc", rdy_q[0] - t, 73);

        // Burst 0x3C, 0xC3, 0xFF against the slave model, which answers 0x11, 0x22, 0x33.
        loop4 = 1'b0;
        clear_rec();
        s_rx_q.delete();
        s_tx_q.push_back(8'h11);
        s_tx_q.push_back(8'h22);
        s_tx_q.push_back(8'h33);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        send(8'h3C, 1'b0, t);
        send(8'hC3, 1'b0, t1);
        send(8'hFF, 1'b1, n);
        wait_idle();
        check("burst_ssel_falls", sf_q.size(), 1);
        check("burst_ssel_rises", sr_q.size(), 1);
        check("burst_rx_pulses", rxv_q.size(), 3);
        check("burst_rise_count", rise_q.size(), 24);
        if (rise_q.size() > 8) check("burst_b2_first_rise", rise_q[8] - t1, 5);
        check("burst_slave_count", s_rx_q.size(), 3);
        if (s_rx_q.size() == 3) begin
            check("burst_slave_b0", s_rx_q[0], 8'h3C);
            check("burst_slave_b1", s_rx_q[1], 8'hC3);
            check("burst_slave_b2", s_rx_q[2], 8'hFF);
        end
        bad = 0;
        for (int i = 0; i < rise_q.size(); i++) begin
            if (i < fall_q.size() && fall_q[i] - rise_q[i] != 4) bad++;
            if (i > 0 && rise_q[i] - fall_q[i-1] < 4) bad++;
        end
        check("burst_sck_shape", bad, 0);

        // Stall 50 cycles in NEXT, then resume with 0x81.
        loop4 = 1'b1;
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h81);
        send(8'h42, 1'b0, t);
        wait_ready();
        bad = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (ssel4 !== 1'b0 || sck4 !== 1'b0 || if4.tx_ready !== 1'b1) bad++;
        end
        check("stall_hold", bad, 0);
        clear_rec();
        send(8'h81, 1'b1, t);
        wait_idle();
        check("resume_rise_count", rise_q.size(), 8);
        if (rise_q.size() > 0) check("resume_first_rise", rise_q[0] - t, 5);

        // Reset on the 5th SCK rise of 0x5A: no rx_valid, clean return to reset values.
        clear_rec();
        send(8'h5A, 1'b1, t);
        n = 0;
        while (rise_q.size() < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach_rise5", rise_q.size(), 5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ssel", ssel4, 1);
        check("rst_sck", sck4, 0);
        check("rst_mosi", mosi4, 0);
        check("rst_busy", if4.busy, 0);
        check("rst_rx_valid", if4.rx_valid, 0);
        check("rst_rx_data", if4.rx_data, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_no_rx_pulse", rxv_q.size(), 0);
        clear_rec();
        exp_q.push_back(8'h12);
        send(8'h12, 1'b1, t);
        wait_idle();
        b = 8'h00;
        foreach (mosi_q[i]) b = {b[6:0], mosi_q[i]};
        check("post_rst_mosi_bits", b, 8'h12);
        check("post_rst_rx_pulses", rxv_q.size(), 1);

        // CLK_DIV=6 instance, slave returns 0x96.
        sel6 = 1'b1;
        #1;
        clear_rec();
        s_rx_q.delete();
        s_tx_q.push_back(8'h96);
        exp_q.push_back(8'h96);
        send(8'h3E, 1'b1, t);
        wait_idle();
        check("d6_rise_count", rise_q.size(), 8);
        check("d6_fall_count", fall_q.size(), 8);
        if (rise_q.size() > 0) check("d6_first_rise", rise_q[0] - t, 7);
        bad = 0;
        for (int i = 0; i < rise_q.size(); i++) begin
            if (i < fall_q.size() && fall_q[i] - rise_q[i] != 6) bad++;
            if (i > 0 && rise_q[i] - fall_q[i-1] != 6) bad++;
        end
        check("d6_sck_half_periods", bad, 0);
        if (rxv_q.size() > 0) check("d6_rx_valid_cyc", rxv_q[0] - t, 97);
        if (sr_q.size() > 0) check("d6_ssel_rise_cyc", sr_q[0] - t, 103);
        if (s_rx_q.size() > 0) check("d6_slave_rx", s_rx_q[0], 8'h3E);

        check("rx_pending", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
